tile_operand_feeder: RTL and testbench

- Hardware replacement for the bench-side operand feeder of deit_core.
- Holds weight and activation tiles in NUM_BANKS banks, so the host can fill one bank while deit_core streams from another.
- Drives in_weight_vec / in_act_vec in response to the core's ctrl_weight_load_en / ctrl_input_stream_en.
- Generalises the fixed 12-weight / 16-activation feeder: parametrised shape and depth, programmable stream lengths, selectable end-of-stream policy (hold last or zero-pad).

---
 rtl/tile_operand_feeder_if.sv | 54 +++++
 rtl/tile_operand_feeder.sv | 213 +++++++++++++++++++++
 tb/tb_tile_operand_feeder.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_operand_feeder_if.sv
// Bundle of every non-clock signal of tile_operand_feeder.
//   master : host / deit_core side (drives writes, config, enables, err_clr)
//   slave  : the feeder (drives operand vectors, done pulses, error flag)
// Host port: host_wr_en/sel/bank/addr/data write one vector into the
// weight (sel=0) or activation (sel=1) memory of a bank.
// Config: cfg_bank, cfg_w_len, cfg_in_len, cfg_pad_mode, latched on enable rise.
// Core side: ctrl_weight_load_en / ctrl_input_stream_en in,
// in_weight_vec / in_act_vec and w_done / in_done out.
// Error: err_wr_conflict (sticky) and err_clr.
interface tile_operand_feeder_if #(
  parameter int ARRAY_ROW  = 16,
  parameter int ARRAY_COL  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int W_DEPTH    = 16,
  parameter int IN_DEPTH   = 64,
  parameter int NUM_BANKS  = 2
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int W_AW   = $clog2(W_DEPTH);
  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int HOST_W = DATA_WIDTH * ((ARRAY_ROW > ARRAY_COL) ? ARRAY_ROW : ARRAY_COL);

  logic                          host_wr_en;
  logic                          host_wr_sel;
  logic [BANK_W-1:0]             host_wr_bank;
  logic [IN_AW-1:0]              host_wr_addr;
  logic [HOST_W-1:0]             host_wr_data;
  logic [BANK_W-1:0]             cfg_bank;
  logic [W_AW:0]                 cfg_w_len;
  logic [IN_AW:0]                cfg_in_len;
  logic                          cfg_pad_mode;
  logic                          ctrl_weight_load_en;
  logic                          ctrl_input_stream_en;
  logic [ARRAY_COL*DATA_WIDTH-1:0] in_weight_vec;
  logic [ARRAY_ROW*DATA_WIDTH-1:0] in_act_vec;
  logic                          w_done;
  logic                          in_done;
  logic                          err_clr;
  logic                          err_wr_conflict;

  modport master (
    output host_wr_en, host_wr_sel, host_wr_bank, host_wr_addr, host_wr_data,
    output cfg_bank, cfg_w_len, cfg_in_len, cfg_pad_mode,
    output ctrl_weight_load_en, ctrl_input_stream_en, err_clr,
    input  in_weight_vec, in_act_vec, w_done, in_done, err_wr_conflict
  );

  modport slave (
    input  host_wr_en, host_wr_sel, host_wr_bank, host_wr_addr, host_wr_data,
    input  cfg_bank, cfg_w_len, cfg_in_len, cfg_pad_mode,
    input  ctrl_weight_load_en, ctrl_input_stream_en, err_clr,
    output in_weight_vec, in_act_vec, w_done, in_done, err_wr_conflict
  );
endinterface

// File: rtl/tile_operand_feeder.sv
// Banked operand feeder for deit_core.
// tile_operand_feeder_chan : one banked vector memory plus its stream FSM
//   (IDLE/STREAM/TAIL); used once for weights and once for activations.
// tile_operand_feeder      : top; clk, rst (sync, active-high) and the
//   tile_operand_feeder_if slave modport. Routes host writes, drops writes
//   that hit a bank being streamed by the same channel type, and keeps the
//   sticky err_wr_conflict flag.

module tile_operand_feeder_chan #(
  parameter int LANES      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_BANKS  = 2,
  parameter bit HOLD_IDLE  = 1'b1,
  localparam int VW = LANES * DATA_WIDTH,
  localparam int AW = $clog2(DEPTH),
  localparam int BW = $clog2(NUM_BANKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [BW-1:0] wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [VW-1:0] wr_data,
  input  logic [BW-1:0] cfg_bank,
  input  logic [AW:0]   cfg_len,
  input  logic          cfg_pad,
  input  logic          en,
  output logic          rd_active,
  output logic [BW-1:0] rd_bank,
  output logic [VW-1:0] vec,
  output logic          done
);
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_TAIL} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [VW-1:0] mem [NUM_BANKS*DEPTH];

  state_t        state_q, state_n;
  logic [AW-1:0] ptr_q, ptr_n;
  logic [BW-1:0] bank_q, bank_n;
  logic [AW:0]   len_q, len_n;
  logic          pad_q, pad_n;
  logic [VW-1:0] vec_q, vec_n;
  logic          done_q, done_n;

  logic [AW:0]   cfg_len_clamped;
  logic [BW-1:0] cur_bank;
  logic [AW:0]   cur_len;
  logic          cur_pad;
  logic [AW:0]   last_idx;
  logic [AW-1:0] rd_addr;
  logic          rd_zero;

  // Memory contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  assign cfg_len_clamped = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;

  // On the rise cycle the bank being read is the live cfg_bank, not the
  // latched one, so the conflict check must see it too.
  assign rd_active = en;
  assign rd_bank   = (state_q == S_IDLE) ? cfg_bank : bank_q;

  always_comb begin
    state_n  = state_q;
    ptr_n    = ptr_q;
    bank_n   = bank_q;
    len_n    = len_q;
    pad_n    = pad_q;
    done_n   = 1'b0;
    vec_n    = HOLD_IDLE ? vec_q : '0;
    cur_bank = bank_q;
    cur_len  = len_q;
    cur_pad  = pad_q;
    last_idx = '0;
    rd_addr  = ptr_q;
    rd_zero  = 1'b0;

    if (!en) begin
      state_n = S_IDLE;
      ptr_n   = '0;
    end else begin
      if (state_q == S_IDLE) begin
        cur_bank = cfg_bank;
        cur_len  = cfg_len_clamped;
        cur_pad  = cfg_pad;
        bank_n   = cfg_bank;
        len_n    = cfg_len_clamped;
        pad_n    = cfg_pad;
      end
      last_idx = cur_len - (AW+1)'(1);

      if (state_q == S_TAIL) begin
        // A zero-length stream has no "last vector" to hold.
        if (cur_pad || (cur_len == '0)) rd_zero = 1'b1;
        else                            rd_addr = last_idx[AW-1:0];
      end else if (cur_len == '0) begin
        rd_zero = 1'b1;
        done_n  = 1'b1;
        state_n = S_TAIL;
      end else begin
        // ptr wraps to 0 when len == DEPTH; TAIL never reads through it.
        ptr_n = ptr_q + AW'(1);
        if ({1'b0, ptr_q} == last_idx) begin
          done_n  = 1'b1;
          state_n = S_TAIL;
        end else begin
          state_n = S_STREAM;
        end
      end

      vec_n = rd_zero ? '0 : mem[{cur_bank, rd_addr}];
    end
  end

  // ---- stage p0 -> output register (1-cycle read latency) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      bank_q  <= '0;
      len_q   <= '0;
      pad_q   <= 1'b0;
      vec_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      bank_q  <= bank_n;
      len_q   <= len_n;
      pad_q   <= pad_n;
      vec_q   <= vec_n;
      done_q  <= done_n;
    end
  end

  assign vec  = vec_q;
  assign done = done_q;
endmodule

module tile_operand_feeder #(
  parameter int ARRAY_ROW  = 16,
  parameter int ARRAY_COL  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int W_DEPTH    = 16,
  parameter int IN_DEPTH   = 64,
  parameter int NUM_BANKS  = 2
) (
  input logic                 clk,
  input logic                 rst,
  tile_operand_feeder_if.slave bus
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int W_AW   = $clog2(W_DEPTH);
  localparam int IN_AW  = $clog2(IN_DEPTH);

  logic              w_rd_active, a_rd_active;
  logic [BANK_W-1:0] w_rd_bank, a_rd_bank;
  logic              w_hit, a_hit, conflict, w_we, a_we;
  logic              err_q;
  logic              unused_host;

  // A write only collides with the channel reading the same memory type.
  assign w_hit    = w_rd_active && (w_rd_bank == bus.host_wr_bank);
  assign a_hit    = a_rd_active && (a_rd_bank == bus.host_wr_bank);
  assign conflict = bus.host_wr_en && (bus.host_wr_sel ? a_hit : w_hit);
  assign w_we     = bus.host_wr_en && !bus.host_wr_sel && !w_hit;
  assign a_we     = bus.host_wr_en &&  bus.host_wr_sel && !a_hit;

  // Upper address/data bits are legitimately ignored for the narrower memory.
  assign unused_host = ^{bus.host_wr_addr, bus.host_wr_data};

  tile_operand_feeder_chan #(
    .LANES(ARRAY_COL), .DATA_WIDTH(DATA_WIDTH), .DEPTH(W_DEPTH),
    .NUM_BANKS(NUM_BANKS), .HOLD_IDLE(1'b1)
  ) u_w (
    .clk(clk), .rst(rst),
    .wr_en(w_we), .wr_bank(bus.host_wr_bank),
    .wr_addr(bus.host_wr_addr[W_AW-1:0]),
    .wr_data(bus.host_wr_data[ARRAY_COL*DATA_WIDTH-1:0]),
    .cfg_bank(bus.cfg_bank), .cfg_len(bus.cfg_w_len), .cfg_pad(bus.cfg_pad_mode),
    .en(bus.ctrl_weight_load_en),
    .rd_active(w_rd_active), .rd_bank(w_rd_bank),
    .vec(bus.in_weight_vec), .done(bus.w_done)
  );

  tile_operand_feeder_chan #(
    .LANES(ARRAY_ROW), .DATA_WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH),
    .NUM_BANKS(NUM_BANKS), .HOLD_IDLE(1'b0)
  ) u_a (
    .clk(clk), .rst(rst),
    .wr_en(a_we), .wr_bank(bus.host_wr_bank),
    .wr_addr(bus.host_wr_addr[IN_AW-1:0]),
    .wr_data(bus.host_wr_data[ARRAY_ROW*DATA_WIDTH-1:0]),
    .cfg_bank(bus.cfg_bank), .cfg_len(bus.cfg_in_len), .cfg_pad(bus.cfg_pad_mode),
    .en(bus.ctrl_input_stream_en),
    .rd_active(a_rd_active), .rd_bank(a_rd_bank),
    .vec(bus.in_act_vec), .done(bus.in_done)
  );

  // A new conflict wins over err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)              err_q <= 1'b0;
    else if (conflict)    err_q <= 1'b1;
    else if (bus.err_clr) err_q <= 1'b0;
  end

  assign bus.err_wr_conflict = err_q;
endmodule

// File: tb/tb_tile_operand_feeder.sv
module tb_tile_operand_feeder;
  localparam int ROW = 16, COL = 16, DW = 8, WD = 16, ID = 64, NB = 2;
  localparam int WVW = COL * DW;
  localparam int AVW = ROW * DW;
  localparam int HW  = DW * ((ROW > COL) ? ROW : COL);
  localparam int CW  = (WVW > AVW) ? WVW : AVW;
  localparam int BW  = $clog2(NB);
  localparam int WAW = $clog2(WD);
  localparam int IAW = $clog2(ID);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tile_operand_feeder_if #(.ARRAY_ROW(ROW), .ARRAY_COL(COL), .DATA_WIDTH(DW),
    .W_DEPTH(WD), .IN_DEPTH(ID), .NUM_BANKS(NB)) bus ();

  tile_operand_feeder #(.ARRAY_ROW(ROW), .ARRAY_COL(COL), .DATA_WIDTH(DW),
    .W_DEPTH(WD), .IN_DEPTH(ID), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: memory images plus per-channel "cycles since rise" count.
  logic [WVW-1:0] m_wmem [NB][WD];
  logic [AVW-1:0] m_amem [NB][ID];
  bit   m_won, m_aon, m_wpad, m_apad;
  int   m_wk, m_ak, m_wbank, m_abank, m_wlen, m_alen;
  logic [WVW-1:0] e_wvec;
  logic [AVW-1:0] e_avec;
  bit   e_wd, e_ad, e_err;

  task automatic check_vec(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", nm, act, exp);
    else n_pass++;
  endtask

  function automatic int clampi(input int v, input int d);
    return (v > d) ? d : v;
  endfunction

  // Predict the next edge from the inputs now applied, clock it, compare.
  task automatic step();
    bit conf;
    if (rst) begin
      m_won = 0; m_aon = 0; m_wk = 0; m_ak = 0;
      m_wbank = 0; m_abank = 0; m_wlen = 0; m_alen = 0; m_wpad = 0; m_apad = 0;
      e_wvec = '0; e_avec = '0; e_wd = 0; e_ad = 0; e_err = 0;
    end else begin
      if (bus.ctrl_weight_load_en) begin
        if (!m_won) begin
          m_wbank = int'(bus.cfg_bank); m_wlen = clampi(int'(bus.cfg_w_len), WD);
          m_wpad = bus.cfg_pad_mode; m_wk = 0;
        end else m_wk++;
        if (m_wlen == 0) begin
          e_wvec = '0; e_wd = (m_wk == 0);
        end else begin
          if (m_wk < m_wlen) e_wvec = m_wmem[m_wbank][m_wk];
          else e_wvec = m_wpad ? '0 : m_wmem[m_wbank][m_wlen-1];
          e_wd = (m_wk == m_wlen - 1);
        end
      end else e_wd = 0;
      m_won = bus.ctrl_weight_load_en;

      if (bus.ctrl_input_stream_en) begin
        if (!m_aon) begin
          m_abank = int'(bus.cfg_bank); m_alen = clampi(int'(bus.cfg_in_len), ID);
          m_apad = bus.cfg_pad_mode; m_ak = 0;
        end else m_ak++;
        if (m_alen == 0) begin
          e_avec = '0; e_ad = (m_ak == 0);
        end else begin
          if (m_ak < m_alen) e_avec = m_amem[m_abank][m_ak];
          else e_avec = m_apad ? '0 : m_amem[m_abank][m_alen-1];
          e_ad = (m_ak == m_alen - 1);
        end
      end else begin
        e_avec = '0; e_ad = 0;
      end
      m_aon = bus.ctrl_input_stream_en;

      conf = bus.host_wr_en && (bus.host_wr_sel ?
               (m_aon && m_abank == int'(bus.host_wr_bank)) :
               (m_won && m_wbank == int'(bus.host_wr_bank)));
      if (bus.host_wr_en && !conf) begin
        if (bus.host_wr_sel) m_amem[bus.host_wr_bank][bus.host_wr_addr] = bus.host_wr_data[AVW-1:0];
        else m_wmem[bus.host_wr_bank][int'(bus.host_wr_addr) % WD] = bus.host_wr_data[WVW-1:0];
      end
      if (conf) e_err = 1;
      else if (bus.err_clr) e_err = 0;
    end
    @(posedge clk);
    #1;
    check_vec("wvec", CW'(bus.in_weight_vec), CW'(e_wvec));
    check_vec("avec", CW'(bus.in_act_vec), CW'(e_avec));
    check_bit("w_done", bus.w_done, e_wd);
    check_bit("in_done", bus.in_done, e_ad);
    check_bit("err", bus.err_wr_conflict, e_err);
  endtask

  task automatic host_write(input logic sel, input int bank, input int addr, input logic [HW-1:0] data);
    bus.host_wr_en = 1'b1; bus.host_wr_sel = sel;
    bus.host_wr_bank = BW'(bank); bus.host_wr_addr = IAW'(addr); bus.host_wr_data = data;
    step();
    bus.host_wr_en = 1'b0;
  endtask

  function automatic logic [HW-1:0] rnd_data();
    return HW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  typedef struct {
    logic       w_en;
    logic       a_en;
    logic [7:0] w_b;
    logic [7:0] a_b;
    logic       wd;
    logic       ad;
  } leg_t;
  leg_t tbl [21];

  logic [AVW-1:0] b1v0;

  initial begin
    for (int i = 0; i < 20; i++) begin
      tbl[i].w_en = 1; tbl[i].a_en = 1;
      tbl[i].w_b = 8'((i < 12) ? i + 1 : 12);
      tbl[i].a_b = 8'((i < 16) ? 16 + i : 31);
      tbl[i].wd = (i == 11); tbl[i].ad = (i == 15);
    end
    tbl[20].w_en = 0; tbl[20].a_en = 0; tbl[20].w_b = 8'd12; tbl[20].a_b = 8'h00;
    tbl[20].wd = 0; tbl[20].ad = 0;

    rst = 1'b1;
    bus.host_wr_en = 0; bus.host_wr_sel = 0; bus.host_wr_bank = '0; bus.host_wr_addr = '0;
    bus.host_wr_data = '0; bus.cfg_bank = '0; bus.cfg_w_len = '0; bus.cfg_in_len = '0;
    bus.cfg_pad_mode = 0; bus.ctrl_weight_load_en = 0; bus.ctrl_input_stream_en = 0;
    bus.err_clr = 0;
    step(); step();
    check_vec("reset_wvec", CW'(bus.in_weight_vec), '0);
    check_bit("reset_err", bus.err_wr_conflict, 1'b0);
    rst = 1'b0;

    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < WD; a++) host_write(1'b0, b, a, rnd_data());
      for (int a = 0; a < ID; a++) host_write(1'b1, b, a, rnd_data());
    end

    // Legacy equivalence
    for (int i = 0; i < 12; i++) host_write(1'b0, 0, i, HW'({COL{8'(i + 1)}}));
    for (int i = 0; i < 16; i++) host_write(1'b1, 0, i, HW'({ROW{8'(16 + i)}}));
    bus.cfg_bank = '0; bus.cfg_w_len = (WAW+1)'(12); bus.cfg_in_len = (IAW+1)'(16);
    bus.cfg_pad_mode = 0;
    for (int i = 0; i < 21; i++) begin
      bus.ctrl_weight_load_en = tbl[i].w_en; bus.ctrl_input_stream_en = tbl[i].a_en;
      step();
      check_vec("leg_w", CW'(bus.in_weight_vec), CW'({COL{tbl[i].w_b}}));
      check_vec("leg_a", CW'(bus.in_act_vec), CW'({ROW{tbl[i].a_b}}));
      check_bit("leg_wd", bus.w_done, tbl[i].wd);
      check_bit("leg_ad", bus.in_done, tbl[i].ad);
    end

    // Zero-pad
    bus.cfg_in_len = (IAW+1)'(5); bus.cfg_pad_mode = 1; bus.ctrl_input_stream_en = 1;
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j == 5) check_vec("zp_v4", CW'(bus.in_act_vec), CW'({ROW{8'h14}}));
      if (j == 6) check_vec("zp_pad", CW'(bus.in_act_vec), '0);
    end
    bus.ctrl_input_stream_en = 0; step();
    check_vec("zp_drop", CW'(bus.in_act_vec), '0);

    // Ping-pong: fill bank1 while streaming bank0
    bus.cfg_bank = '0; bus.cfg_in_len = (IAW+1)'(16); bus.cfg_pad_mode = 0;
    bus.ctrl_input_stream_en = 1;
    for (int a = 0; a < ID; a++) begin
      logic [HW-1:0] d;
      d = rnd_data();
      if (a == 0) b1v0 = d[AVW-1:0];
      host_write(1'b1, 1, a, d);
    end
    check_bit("pp_no_err", bus.err_wr_conflict, 1'b0);
    bus.ctrl_input_stream_en = 0; step();
    bus.cfg_bank = BW'(1); bus.cfg_in_len = (IAW+1)'(ID); bus.ctrl_input_stream_en = 1;
    step();
    check_vec("pp_b1v0", CW'(bus.in_act_vec), CW'(b1v0));
    for (int j = 0; j < ID + 1; j++) step();
    bus.ctrl_input_stream_en = 0; step();

    // Conflict
    bus.cfg_bank = '0; bus.cfg_in_len = (IAW+1)'(8); bus.ctrl_input_stream_en = 1;
    step(); step();
    host_write(1'b0, 0, 3, rnd_data());
    check_bit("other_type_ok", bus.err_wr_conflict, 1'b0);
    host_write(1'b1, 0, 3, {HW{1'b1}});
    check_bit("conf_set", bus.err_wr_conflict, 1'b1);
    step(); step();
    check_bit("conf_sticky", bus.err_wr_conflict, 1'b1);
    bus.err_clr = 1; host_write(1'b1, 0, 3, {HW{1'b1}});
    check_bit("clr_vs_conf", bus.err_wr_conflict, 1'b1);
    step(); bus.err_clr = 0;
    check_bit("conf_clr", bus.err_wr_conflict, 1'b0);
    bus.ctrl_input_stream_en = 0; step();
    bus.ctrl_input_stream_en = 1;
    for (int j = 1; j <= 6; j++) begin
      step();
      if (j == 4) check_vec("conf_dropped", CW'(bus.in_act_vec), CW'({ROW{8'h13}}));
    end
    bus.ctrl_input_stream_en = 0; step();

    // Edge lengths
    bus.cfg_w_len = '0; bus.cfg_in_len = '0; bus.cfg_pad_mode = 0;
    bus.ctrl_weight_load_en = 1; bus.ctrl_input_stream_en = 1;
    step();
    check_bit("len0_wd", bus.w_done, 1'b1);
    check_bit("len0_ad", bus.in_done, 1'b1);
    check_vec("len0_a", CW'(bus.in_act_vec), '0);
    check_vec("len0_w", CW'(bus.in_weight_vec), '0);
    step(); step();
    bus.ctrl_weight_load_en = 0; bus.ctrl_input_stream_en = 0; step();
    bus.cfg_w_len = (WAW+1)'(2*WD - 1); bus.cfg_in_len = (IAW+1)'(ID + 5);
    bus.ctrl_weight_load_en = 1; bus.ctrl_input_stream_en = 1;
    for (int j = 1; j <= ID + 4; j++) begin
      step();
      if (j == WD) check_bit("wclamp_done", bus.w_done, 1'b1);
      if (j == ID) check_bit("aclamp_done", bus.in_done, 1'b1);
      if (j == ID + 3) check_vec("aclamp_tail", CW'(bus.in_act_vec), CW'(m_amem[0][ID-1]));
    end
    bus.ctrl_weight_load_en = 0; bus.ctrl_input_stream_en = 0; step();

    // Reset mid-stream
    bus.cfg_bank = BW'(1); bus.cfg_w_len = (WAW+1)'(WD); bus.cfg_in_len = (IAW+1)'(20);
    bus.ctrl_weight_load_en = 1; bus.ctrl_input_stream_en = 1;
    for (int j = 0; j < 7; j++) step();
    rst = 1'b1; step();
    check_vec("rst_w", CW'(bus.in_weight_vec), '0);
    check_vec("rst_a", CW'(bus.in_act_vec), '0);
    check_bit("rst_wd", bus.w_done, 1'b0);
    check_bit("rst_ad", bus.in_done, 1'b0);
    rst = 1'b0; bus.ctrl_weight_load_en = 0; bus.ctrl_input_stream_en = 0; step();
    bus.ctrl_weight_load_en = 1; bus.ctrl_input_stream_en = 1;
    step();
    check_vec("rst_restart", CW'(bus.in_act_vec), CW'(b1v0));
    for (int j = 0; j < 24; j++) step();
    bus.ctrl_weight_load_en = 0; bus.ctrl_input_stream_en = 0; step();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) bus.ctrl_weight_load_en = ~bus.ctrl_weight_load_en;
      if ($urandom_range(0, 9) == 0) bus.ctrl_input_stream_en = ~bus.ctrl_input_stream_en;
      bus.cfg_bank     = BW'($urandom_range(0, NB - 1));
      bus.cfg_w_len    = (WAW+1)'($urandom_range(0, 2*WD - 1));
      bus.cfg_in_len   = (IAW+1)'(($urandom_range(0, 1) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 2*ID - 1));
      bus.cfg_pad_mode = 1'($urandom_range(0, 1));
      bus.host_wr_en   = ($urandom_range(0, 2) == 0);
      bus.host_wr_sel  = 1'($urandom_range(0, 1));
      bus.host_wr_bank = BW'($urandom_range(0, NB - 1));
      bus.host_wr_addr = IAW'($urandom_range(0, ID - 1));
      bus.host_wr_data = rnd_data();
      bus.err_clr      = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
